// File: rtl/mac_result_writer_pkg.sv
// Shared types and sizing for the MAC result writer: FSM state encoding, FIFO depth and
// the counter width needed to cover the engine's longest vector.
package mac_writer_package;

   localparam int unsigned MAC_CNT_LEN       = 4096;
   localparam int unsigned MAC_WR_FIFO_DEPTH = 2;
   localparam int unsigned MAC_WR_CNT_W      = $clog2(MAC_CNT_LEN) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } mac_writer_state_t;

endpackage

// File: rtl/mac_result_writer_fifo.sv
// Small synchronous FIFO between the result stream and the memory write port.
// Full/empty are registered so the stream ready never depends on the same-cycle pop.
module mac_result_fifo
   import mac_writer_package::*;
(
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic        push_i,
   input  logic [31:0] data_i,
   input  logic        pop_i,
   output logic [31:0] data_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int unsigned PtrW = $clog2(MAC_WR_FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [31:0]     mem_q [MAC_WR_FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            full_q, empty_q;
   logic            push_ok, pop_ok;

   assign push_ok = push_i & ~full_q;
   assign pop_ok  = pop_i & ~empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < int'(MAC_WR_FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CntW'(MAC_WR_FIFO_DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/mac_result_writer.sv
// Drains the MAC result stream into memory at base + k*stride, one job per start pulse,
// and reports completion with a one-cycle done pulse.
module mac_result_writer
   import mac_writer_package::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = MAC_WR_CNT_W
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              d_TVALID,
   output logic              d_TREADY,
   input  logic [31:0]       d_TDATA,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              reg_start,
   input  logic [ADDR_W-1:0] reg_base_addr,
   input  logic [15:0]       reg_stride,
   input  logic [CNT_W-1:0]  reg_n_out,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  wr_cnt
);

   mac_writer_state_t state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [15:0]       stride_q;
   logic [CNT_W-1:0]  n_q, acc_cnt_q, wr_cnt_q;
   logic              busy_q, done_q;

   logic              fifo_full, fifo_empty;
   logic [31:0]       fifo_head;
   logic              push, pop, last_wr;

   assign d_TREADY = (state_q == StRun) & ~fifo_full & (acc_cnt_q < n_q);
   assign mem_req  = (state_q == StRun) & ~fifo_empty;
   assign push     = d_TVALID & d_TREADY;
   assign pop      = mem_req & mem_gnt;
   // n_q is non-zero whenever we are in RUN, so the subtraction cannot underflow there.
   assign last_wr  = (wr_cnt_q == n_q - CNT_W'(1));

   mac_result_fifo u_fifo (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .push_i   (push),
      .data_i   (d_TDATA),
      .pop_i    (pop),
      .data_o   (fifo_head),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         stride_q  <= '0;
         n_q       <= '0;
         acc_cnt_q <= '0;
         wr_cnt_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (reg_start) begin
                  ptr_q     <= reg_base_addr;
                  stride_q  <= reg_stride;
                  n_q       <= reg_n_out;
                  acc_cnt_q <= '0;
                  wr_cnt_q  <= '0;
                  if (reg_n_out != '0) begin
                     state_q <= StRun;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (push) begin
                  acc_cnt_q <= acc_cnt_q + 1'b1;
               end
               if (pop) begin
                  ptr_q    <= ptr_q + ADDR_W'(stride_q);
                  wr_cnt_q <= wr_cnt_q + 1'b1;
                  if (last_wr) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr  = ptr_q;
   assign mem_wdata = fifo_head;
   assign mem_be    = {4{mem_req}};
   assign busy      = busy_q;
   assign done      = done_q;
   assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_mac_result_writer.sv
// Bench for mac_result_writer: a stream source and grant driver, a write monitor, and a
// job-level model predicting each write from base, stride and the queued beats.
module tb_mac_result_writer;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 13;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n = 1'b0;
   logic              d_TVALID = 1'b0;
   logic              d_TREADY;
   logic [31:0]       d_TDATA = '0;
   logic              mem_req;
   logic              mem_gnt = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              reg_start = 1'b0;
   logic [ADDR_W-1:0] reg_base_addr = '0;
   logic [15:0]       reg_stride = '0;
   logic [CNT_W-1:0]  reg_n_out = '0;
   logic              busy, done;
   logic [CNT_W-1:0]  wr_cnt;

   mac_result_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .d_TVALID      (d_TVALID),
      .d_TREADY      (d_TREADY),
      .d_TDATA       (d_TDATA),
      .mem_req       (mem_req),
      .mem_gnt       (mem_gnt),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_be        (mem_be),
      .reg_start     (reg_start),
      .reg_base_addr (reg_base_addr),
      .reg_stride    (reg_stride),
      .reg_n_out     (reg_n_out),
      .busy          (busy),
      .done          (done),
      .wr_cnt        (wr_cnt)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] src_q[$];
   wr_t         got_q[$];
   wr_t         exp_q[$];
   bit          vld_rand = 0, gnt_rand = 0, gnt_hold_low = 0, gnt_pulse = 0;
   int          stall_cnt = 0;
   int          job_n = 0, start_cyc = 0;

   always @(posedge ap_clk) cyc <= cyc + 1;

   // Monitor at the falling edge, then drive the next cycle's stream/grant just after the rising edge.
   bit          d_hs, prev_pend = 0;
   logic [31:0] prev_addr, prev_data;
   always begin
      @(negedge ap_clk);
      d_hs = ap_rst_n && d_TVALID && d_TREADY;
      if (ap_rst_n) begin
         checks++;
         if (mem_be !== (mem_req ? 4'hF : 4'h0)) begin
            failures++;
            $display("FAIL mem_be: got %h expected %h", mem_be, mem_req ? 4'hF : 4'h0);
         end
         if (prev_pend) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data) begin
               failures++;
               $display("FAIL req_stable: got req=%b addr=%h data=%h expected req=1 addr=%h data=%h",
                        mem_req, mem_addr, mem_wdata, prev_addr, prev_data);
            end
         end
         if (mem_req && mem_gnt) got_q.push_back('{mem_addr, mem_wdata, cyc});
      end
      prev_pend = ap_rst_n && mem_req && !mem_gnt;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
      @(posedge ap_clk);
      #1;
      if (d_hs && src_q.size() > 0) void'(src_q.pop_front());
      if (!d_TVALID || d_hs) d_TVALID = (src_q.size() > 0) && (!vld_rand || $urandom_range(3) != 0);
      if (d_TVALID) begin
         if (src_q.size() == 0) d_TVALID = 1'b0;
         else d_TDATA = src_q[0];
      end
      if (gnt_pulse) begin
         mem_gnt = 1'b1;
         gnt_pulse = 0;
      end else if (gnt_hold_low) begin
         mem_gnt = 1'b0;
      end else if (stall_cnt > 0) begin
         mem_gnt = 1'b0;
         stall_cnt--;
      end else if (gnt_rand) begin
         mem_gnt = 1'($urandom_range(1));
      end else begin
         mem_gnt = 1'b1;
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #2;
   endtask

   task automatic start_job(input logic [31:0] base, input logic [15:0] stride, input int n);
      logic [31:0] a = base;
      exp_q.delete();
      got_q.delete();
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{a, src_q[k], 0});
         a = a + {16'h0, stride};
      end
      job_n         = n;
      reg_base_addr = base;
      reg_stride    = stride;
      reg_n_out     = CNT_W'(n);
      reg_start     = 1'b1;
      start_cyc     = cyc;
      tick();
      reg_start = 1'b0;
   endtask

   task automatic finish_job(input string name, input bit b2b);
      int c = 0;
      int done_cyc;
      int exp_done;
      while (c < 3000) begin
         @(negedge ap_clk);
         if (done) break;
         c++;
      end
      done_cyc = cyc;
      checks++;
      if (c >= 3000) begin
         failures++;
         $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, c);
         ap_rst_n = 1'b0;
         tick();
         ap_rst_n = 1'b1;
         tick();
         return;
      end
      checks++;
      if (got_q.size() != job_n) begin
         failures++;
         $display("FAIL %s_count: got %0d writes expected %0d", name, got_q.size(), job_n);
      end
      for (int i = 0; i < job_n && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
            failures++;
            $display("FAIL %s_write%0d: got %h=%h expected %h=%h", name, i, got_q[i].addr,
                     got_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
         if (b2b) begin
            checks++;
            if (got_q[i].cyc != start_cyc + 2 + i) begin
               failures++;
               $display("FAIL %s_cycle%0d: got cycle %0d expected %0d", name, i,
                        got_q[i].cyc - start_cyc, 2 + i);
            end
         end
      end
      exp_done = (job_n == 0 || got_q.size() == 0) ? start_cyc + 1 : got_q[$].cyc + 1;
      checks++;
      if (done_cyc != exp_done || busy !== 1'b0 || wr_cnt !== CNT_W'(job_n)) begin
         failures++;
         $display("FAIL %s_done: got cyc+%0d busy=%b wr_cnt=%0d expected cyc+%0d busy=0 wr_cnt=%0d",
                  name, done_cyc - start_cyc, busy, wr_cnt, exp_done - start_cyc, job_n);
      end
      @(negedge ap_clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || wr_cnt !== CNT_W'(job_n)) begin
         failures++;
         $display("FAIL %s_after: got done=%b busy=%b req=%b wr_cnt=%0d expected 0 0 0 %0d",
                  name, done, busy, mem_req, wr_cnt, job_n);
      end
      tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({d_TREADY, mem_req, mem_addr, mem_wdata, mem_be, busy, done, wr_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_values: got rdy=%b req=%b addr=%h wd=%h be=%h busy=%b done=%b cnt=%0d expected all 0",
                  d_TREADY, mem_req, mem_addr, mem_wdata, mem_be, busy, done, wr_cnt);
      end
      ap_rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      src_q = '{32'd10, 32'd20, 32'd30, 32'd40};
      tick();
      start_job(32'h1000, 16'd4, 4);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy: got %b expected 1", busy);
      end
      finish_job("basic", 1'b1);
   endtask

   task automatic test_grant_stall();
      for (int i = 0; i < 3; i++) src_q.push_back($urandom);
      tick();
      stall_cnt = 8;
      start_job($urandom & 32'hFFFF_FFFC, 16'h10, 3);
      repeat (4) tick();
      checks++;
      if (d_TREADY !== 1'b0 || mem_req !== 1'b1 || mem_addr !== exp_q[0].addr ||
          mem_wdata !== exp_q[0].data) begin
         failures++;
         $display("FAIL stall_full: got rdy=%b req=%b addr=%h data=%h expected 0 1 %h %h",
                  d_TREADY, mem_req, mem_addr, mem_wdata, exp_q[0].addr, exp_q[0].data);
      end
      finish_job("stall", 1'b0);
   endtask

   task automatic test_overrun();
      src_q = '{32'd1, 32'd2, 32'd3};
      tick();
      start_job(32'h2000, 16'd4, 2);
      finish_job("overrun", 1'b0);
      repeat (3) begin
         @(negedge ap_clk);
         checks++;
         if (d_TREADY !== 1'b0) begin
            failures++;
            $display("FAIL overrun_ready: got %b expected 0", d_TREADY);
         end
      end
      tick();
      start_job(32'h3000, 16'd4, 1);
      finish_job("overrun_next", 1'b0);
      checks++;
      if (got_q.size() != 1 || got_q[0].data !== 32'd3) begin
         failures++;
         $display("FAIL overrun_leftover: got %0d writes first=%h expected 1 write of 3",
                  got_q.size(), got_q.size() > 0 ? got_q[0].data : 32'hx);
      end
   endtask

   task automatic test_empty_and_ignored_start();
      start_job(32'h4000, 16'd4, 0);
      finish_job("empty", 1'b0);
      for (int i = 0; i < 3; i++) src_q.push_back($urandom);
      tick();
      stall_cnt = 6;
      start_job(32'h5000, 16'd8, 3);
      tick();
      reg_base_addr = 32'hDEAD_0000;
      reg_stride    = 16'd100;
      reg_n_out     = CNT_W'(7);
      reg_start     = 1'b1;
      tick();
      reg_start = 1'b0;
      finish_job("ignored_start", 1'b0);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 2; i++) src_q.push_back($urandom);
      tick();
      start_job(32'hFFFF_FFF8, 16'd8, 2);
      finish_job("wrap", 1'b0);
      checks++;
      if (got_q.size() != 2 || got_q[1].addr !== 32'h0000_0000) begin
         failures++;
         $display("FAIL wrap_addr: got %0d writes second=%h expected 00000000", got_q.size(),
                  got_q.size() > 1 ? got_q[1].addr : 32'hx);
      end
   endtask

   task automatic test_reset_mid_job();
      int c = 0;
      logic [31:0] w;
      for (int i = 0; i < 3; i++) src_q.push_back($urandom);
      tick();
      gnt_hold_low = 1;
      start_job(32'h6000, 16'd4, 3);
      while (!mem_req && c < 50) begin
         tick();
         c++;
      end
      gnt_pulse = 1;
      c = 0;
      while (got_q.size() < 1 && c < 50) begin
         @(negedge ap_clk);
         c++;
      end
      tick();
      ap_rst_n = 1'b0;
      #1;
      checks++;
      if ({d_TREADY, mem_req, mem_addr, mem_wdata, mem_be, busy, done, wr_cnt} !== '0 ||
          got_q.size() != 1) begin
         failures++;
         $display("FAIL midreset_values: got rdy=%b req=%b addr=%h wd=%h be=%h busy=%b cnt=%0d writes=%0d expected all 0 and 1 write",
                  d_TREADY, mem_req, mem_addr, mem_wdata, mem_be, busy, wr_cnt, got_q.size());
      end
      src_q.delete();
      gnt_hold_low = 0;
      repeat (3) tick();
      ap_rst_n = 1'b1;
      tick();
      w = $urandom;
      src_q.push_back(w);
      tick();
      start_job(32'h7000, 16'd4, 1);
      finish_job("after_reset", 1'b0);
      checks++;
      if (got_q.size() != 1 || got_q[0].addr !== 32'h7000 || got_q[0].data !== w) begin
         failures++;
         $display("FAIL after_reset_word: got %0d writes expected 7000=%h", got_q.size(), w);
      end
   endtask

   task automatic test_random();
      vld_rand = 1;
      gnt_rand = 1;
      for (int j = 0; j < 12; j++) begin
         int          n = $urandom_range(8);
         int          extra = $urandom_range(2);
         logic [15:0] stride = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
         for (int i = 0; i < n + extra; i++) src_q.push_back($urandom);
         tick();
         start_job($urandom, stride, n);
         finish_job($sformatf("random%0d", j), 1'b0);
      end
      vld_rand = 0;
      gnt_rand = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_grant_stall();
      test_overrun();
      test_empty_and_ignored_start();
      test_wrap();
      test_reset_mid_job();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
